// File: rtl/bram_cfg_pkg.sv
// Shared encodings, FSM state type and lane-mask helper for the configurable BRAM tile.
package bram_cfg_pkg;

  localparam logic [1:0] MODE_FULL = 2'd0;
  localparam logic [1:0] MODE_HALF = 2'd1;
  localparam logic [1:0] MODE_BYTE = 2'd2;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  // Byte-lane enables for a port of l lanes (l <= 8); mode 3 behaves as full.
  function automatic logic [7:0] lane_mask(input logic [1:0] mode,
                                           input logic [2:0] sub,
                                           input int         l);
    lane_mask = '0;
    for (int i = 0; i < 8; i++) begin
      case (mode)
        MODE_HALF: lane_mask[i] = sub[0] ? (i >= l / 2 && i < l) : (i < l / 2);
        MODE_BYTE: lane_mask[i] = (i == int'(sub));
        default:   lane_mask[i] = (i < l);
      endcase
    end
  endfunction

endpackage

// File: rtl/bram_cfg_lane_mux.sv
// Read-side narrowing: selects a half or byte of the stored word and zero-extends it.
module bram_cfg_lane_mux
  import bram_cfg_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int SUB_W  = 2
) (
  input  logic [DATA_W-1:0] word,
  input  logic [SUB_W-1:0]  sub,
  input  logic [1:0]        mode,
  output logic [DATA_W-1:0] data
);

  always_comb begin
    data = '0;
    case (mode)
      MODE_HALF: data[DATA_W/2-1:0] = sub[0] ? word[DATA_W-1:DATA_W/2] : word[DATA_W/2-1:0];
      MODE_BYTE: data[7:0] = word[int'(sub)*8 +: 8];
      default:   data = word;
    endcase
  end

endmodule

// File: rtl/bram_cfg_port.sv
// Simple dual-port BRAM tile with runtime port widths, write-first forwarding and post-reset clear.
//   state | meaning
//   CLEAR | zeroing one word per cycle from clr_cnt; user ports blocked, busy high
//   RUN   | normal read/write operation
module bram_cfg_port
  import bram_cfg_pkg::*;
#(
  parameter int ADDR_W        = 8,
  parameter int DATA_W        = 32,
  parameter int SUB_W         = $clog2(DATA_W / 8),
  parameter bit INIT_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        cfg_wr_mode,
  input  logic [1:0]        cfg_rd_mode,
  input  logic              cfg_out_reg,
  input  logic              cfg_always_we,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [SUB_W-1:0]  wr_sub,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [SUB_W-1:0]  rd_sub,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              busy
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int L     = DATA_W / 8;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] clr_cnt, clr_cnt_nxt;
  logic              clr_we;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if (INIT_ON_RESET) state <= CLEAR;
      else               state <= RUN;
      clr_cnt <= '0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    clr_we      = 1'b0;
    case (state)
      CLEAR: begin
        clr_we = 1'b1;
        if (clr_cnt == '1) state_nxt = RUN;
        else               clr_cnt_nxt = clr_cnt + ADDR_W'(1);
      end
      default: ;
    endcase
  end

  assign busy = (state == CLEAR);

  logic              user_we;
  logic [L-1:0]      wr_mask;
  logic [DATA_W-1:0] wr_word;

  assign user_we = (wr_en | cfg_always_we) & ~busy;
  assign wr_mask = L'(lane_mask(cfg_wr_mode, 3'(wr_sub), L));

  // Narrow data is replicated across all lanes so the mask alone places it.
  always_comb begin
    case (cfg_wr_mode)
      MODE_HALF: wr_word = {2{wr_data[DATA_W/2-1:0]}};
      MODE_BYTE: wr_word = {L{wr_data[7:0]}};
      default:   wr_word = wr_data;
    endcase
  end

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_cnt] <= '0;
    end else if (user_we) begin
      for (int l = 0; l < L; l++)
        if (wr_mask[l]) mem[wr_addr][l*8 +: 8] <= wr_word[l*8 +: 8];
    end
  end

  logic [DATA_W-1:0] rd_word;

  // Write-first: lanes being written this cycle bypass the array.
  always_comb begin
    rd_word = mem[rd_addr];
    if (user_we && wr_addr == rd_addr) begin
      for (int l = 0; l < L; l++)
        if (wr_mask[l]) rd_word[l*8 +: 8] = wr_word[l*8 +: 8];
    end
  end

  logic [DATA_W-1:0] s1_word;
  logic [SUB_W-1:0]  s1_sub;
  logic              s1_valid;
  logic [DATA_W-1:0] mux_data;
  logic [DATA_W-1:0] s2_data;
  logic              s2_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_word  <= '0;
      s1_sub   <= '0;
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= rd_en & ~busy;
      if (rd_en && !busy) begin
        s1_word <= rd_word;
        s1_sub  <= rd_sub;
      end
    end
  end

  bram_cfg_lane_mux #(
    .DATA_W (DATA_W),
    .SUB_W  (SUB_W)
  ) u_lane_mux (
    .word (s1_word),
    .sub  (s1_sub),
    .mode (cfg_rd_mode),
    .data (mux_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_data  <= '0;
      s2_valid <= 1'b0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) s2_data <= mux_data;
    end
  end

  assign rd_data  = cfg_out_reg ? s2_data  : mux_data;
  assign rd_valid = cfg_out_reg ? s2_valid : s1_valid;

endmodule
